aes_core_arbiter: RTL and testbench

- Shares one aes_cipher_top encryption core between NREQ independent requesters.
- Arbitrates with round-robin priority and drives the core's ld/key/text_in.
- Waits for core done, captures text_out, and returns the ciphertext to the winning requester over a valid/ready response channel.
- Sits between the bus-side request ports and the single cipher instance; a watchdog flags a core that never asserts done.

---
 rtl/aes_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 35 +++
 rtl/aes_core_arbiter.sv | 143 ++++++++++++++
 tb/tb_aes_core_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_arb_pkg.sv
// rtl/aes_arb_pkg.sv - shared types and constants for the AES core arbiter
package aes_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BUSY = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    localparam int DW_DEFAULT = 128;

    // Watchdog counter width; TIMEOUT must fit in it.
    localparam int WD_W = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin first-set-bit picker starting at ptr
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int k;

    // Scan offsets from farthest to nearest so the closest set bit at/after ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        k     = 0;
        any   = |req;
        for (int off = N - 1; off >= 0; off--) begin
            k = int'(ptr) + off;
            if (k >= N) begin
                k = k - N;
            end
            if (req[k[IW-1:0]]) begin
                idx = k[IW-1:0];
            end
        end
        if (any) begin
            grant = N'(1) << idx;
        end
    end

endmodule

// File: rtl/aes_core_arbiter.sv
// rtl/aes_core_arbiter.sv - round-robin sharing of one AES cipher core with done watchdog
module aes_core_arbiter
    import aes_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int DW      = DW_DEFAULT,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_key,
    input  logic [NREQ*DW-1:0] req_text,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [DW-1:0]      rsp_data,
    output logic               rsp_err,
    output logic               core_ld,
    output logic [DW-1:0]      core_key,
    output logic [DW-1:0]      core_text,
    input  logic               core_done,
    input  logic [DW-1:0]      core_text_out,
    output logic               busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t      state;
    arb_state_t      state_next;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_grant;
    logic            pick_any;
    logic [WD_W-1:0] watchdog;
    logic [WD_W-1:0] wd_inc;
    logic            wd_expired;
    logic            done_q;
    logic            done_rise;
    logic            rsp_hs;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign wd_inc     = watchdog + 1'b1;
    assign wd_expired = (wd_inc == WD_W'(TIMEOUT));
    assign done_rise  = core_done & ~done_q;
    assign rsp_hs     = rsp_ready[gnt_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        core_ld    = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    req_ready  = pick_grant;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                core_ld    = 1'b1;
                state_next = ST_BUSY;
            end
            ST_BUSY: begin
                if (done_rise || wd_expired) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = NREQ'(1) << gnt_idx;
                if (rsp_hs) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A done edge coinciding with watchdog expiry is treated as success.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            core_key  <= '0;
            core_text <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            watchdog  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= core_done;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        gnt_idx   <= pick_idx;
                        core_key  <= req_key[int'(pick_idx)*DW +: DW];
                        core_text <= req_text[int'(pick_idx)*DW +: DW];
                    end
                end
                ST_LOAD: begin
                    watchdog <= '0;
                end
                ST_BUSY: begin
                    watchdog <= wd_inc;
                    if (done_rise) begin
                        rsp_data <= core_text_out;
                        rsp_err  <= 1'b0;
                    end else if (wd_expired) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_hs) begin
                        rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb/tb_aes_core_arbiter.sv - randomized self-checking bench with stub cipher core
module tb_aes_core_arbiter;

    localparam int NREQ    = 3;
    localparam int DW      = 128;
    localparam int TIMEOUT = 255;

    localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_key;
    logic [NREQ*DW-1:0] req_text;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;
    logic               core_ld;
    logic [DW-1:0]      core_key;
    logic [DW-1:0]      core_text;
    logic               core_done;
    logic [DW-1:0]      core_text_out;
    logic               busy;

    logic [DW-1:0] key_tb  [NREQ];
    logic [DW-1:0] text_tb [NREQ];

    int checks = 0;
    int errors = 0;
    int ptr    = 0;

    int            stub_lat = 0;
    int            stub_cnt = 0;
    logic [DW-1:0] stub_out = '0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
        assign req_key[gi*DW +: DW]  = key_tb[gi];
        assign req_text[gi*DW +: DW] = text_tb[gi];
    end

    aes_core_arbiter #(
        .NREQ    (NREQ),
        .DW      (DW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_key       (req_key),
        .req_text      (req_text),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .core_ld       (core_ld),
        .core_key      (core_key),
        .core_text     (core_text),
        .core_done     (core_done),
        .core_text_out (core_text_out),
        .busy          (busy)
    );

    // Stand-in cipher: returns the FIPS-197 vector for that input, a scramble otherwise.
    function automatic logic [DW-1:0] stub_fn(input logic [DW-1:0] k, input logic [DW-1:0] t);
        if (k == AES_KEY && t == AES_PT) return AES_CT;
        return k ^ {t[63:0], t[127:64]} ^ 128'h5a5a_0f0f_a5a5_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    // Pulses done for one cycle stub_lat cycles after the ld cycle; 0 means never.
    always @(posedge clk) begin
        if (core_ld) begin
            stub_cnt <= stub_lat;
            stub_out <= stub_fn(core_key, core_text);
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end
    assign core_done     = (stub_cnt == 1);
    assign core_text_out = stub_out;

    function automatic int model_pick(input int mask);
        for (int off = 0; off < NREQ; off++) begin
            int i;
            i = (ptr + off) % NREQ;
            if (mask[i]) return i;
        end
        return 0;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        @(negedge clk);
        rst = 1'b0;
        ptr = 0;
    endtask

    // One transaction from a negedge in IDLE through the response handshake.
    task automatic run_txn(input int mask, input int lat, input int hold, input bit keep,
                           input string tag, output int g_out, output logic [DW-1:0] data_out);
        int            g;
        int            exp_k;
        int            cyc;
        int            lds;
        bit            got;
        bit            bad;
        bit            exp_err;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] ek;
        logic [DW-1:0] et;
        logic [NREQ-1:0] oh;

        req_valid = NREQ'(mask);
        stub_lat  = lat;
        #1;
        g        = model_pick(mask);
        g_out    = g;
        oh       = NREQ'(1) << g;
        ek       = key_tb[g];
        et       = text_tb[g];
        exp_err  = !(lat >= 1 && lat <= TIMEOUT);
        exp_k    = exp_err ? TIMEOUT : lat;
        exp_data = exp_err ? '0 : stub_fn(ek, et);
        data_out = '0;

        checks++;
        if (req_ready !== oh) begin
            errors++;
            $display("FAIL %s grant: req_ready=%b expected=%b", tag, req_ready, oh);
        end

        @(posedge clk);
        #1;
        req_valid = keep ? NREQ'(mask & ~(1 << g)) : '0;
        @(negedge clk);
        checks++;
        if (core_ld !== 1'b1 || core_key !== ek || core_text !== et || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s load: ld=%b key=%h text=%h busy=%b expected ld=1 key=%h text=%h busy=1",
                     tag, core_ld, core_key, core_text, busy, ek, et);
        end

        cyc = 0;
        lds = 0;
        got = 1'b0;
        while (!got && cyc < TIMEOUT + 20) begin
            @(negedge clk);
            cyc++;
            if (core_ld === 1'b1) lds++;
            if (rsp_valid !== '0) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s rsp_wait: no rsp_valid after %0d cycles, expected after %0d", tag, cyc, exp_k + 1);
            return;
        end
        data_out = rsp_data;
        checks++;
        if (rsp_valid !== oh || cyc != exp_k + 1 || lds != 0) begin
            errors++;
            $display("FAIL %s rsp_timing: rsp_valid=%b latency=%0d extra_ld=%0d expected rsp_valid=%b latency=%0d extra_ld=0",
                     tag, rsp_valid, cyc, lds, oh, exp_k + 1);
        end
        checks++;
        if (rsp_data !== exp_data || rsp_err !== exp_err) begin
            errors++;
            $display("FAIL %s rsp_data: data=%h err=%b expected data=%h err=%b",
                     tag, rsp_data, rsp_err, exp_data, exp_err);
        end

        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            rsp_ready = NREQ'($urandom) & ~oh;
            @(negedge clk);
            if (rsp_valid !== oh || rsp_data !== exp_data || rsp_err !== exp_err ||
                core_ld !== 1'b0 || req_ready !== '0) bad = 1'b1;
        end
        if (hold > 0) begin
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s backpressure: rsp_valid=%b data=%h ld=%b req_ready=%b expected held %b %h ld=0 req_ready=0",
                         tag, rsp_valid, rsp_data, core_ld, req_ready, oh, exp_data);
            end
        end

        rsp_ready = oh;
        @(negedge clk);
        rsp_ready = '0;
        ptr = (g + 1) % NREQ;
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake: rsp_valid=%b busy=%b expected 0 0", tag, rsp_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            key_tb[i]  = '0;
            text_tb[i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, core_ld, busy} !== '0 || rsp_data !== '0 ||
            core_key !== '0 || core_text !== '0) begin
            errors++;
            $display("FAIL reset: req_ready=%b rsp_valid=%b err=%b ld=%b busy=%b data=%h key=%h text=%h expected all 0",
                     req_ready, rsp_valid, rsp_err, core_ld, busy, rsp_data, core_key, core_text);
        end
        rst = 1'b0;
        ptr = 0;
    endtask

    task automatic test_single();
        int            g;
        logic [DW-1:0] d;
        do_reset();
        key_tb[0]  = AES_KEY;
        text_tb[0] = AES_PT;
        run_txn(1, 10, 0, 1'b0, "single", g, d);
        checks++;
        if (d !== AES_CT) begin
            errors++;
            $display("FAIL single_vector: data=%h expected=%h", d, AES_CT);
        end
    endtask

    task automatic test_contention();
        int            g;
        int            exp_g [3];
        logic [DW-1:0] d;
        exp_g = '{0, 1, 0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            key_tb[0]  = {$urandom, $urandom, $urandom, $urandom};
            key_tb[1]  = {$urandom, $urandom, $urandom, $urandom};
            text_tb[0] = {$urandom, $urandom, $urandom, $urandom};
            text_tb[1] = {$urandom, $urandom, $urandom, $urandom};
            run_txn(3, 4 + i, 0, 1'b0, "contention", g, d);
            checks++;
            if (g != exp_g[i]) begin
                errors++;
                $display("FAIL contention_order: round %0d granted=%0d expected=%0d", i, g, exp_g[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int            g;
        logic [DW-1:0] d;
        do_reset();
        key_tb[1]  = {$urandom, $urandom, $urandom, $urandom};
        text_tb[1] = {$urandom, $urandom, $urandom, $urandom};
        run_txn(3, 6, 20, 1'b1, "backpressure", g, d);
        run_txn(2, 3, 0, 1'b0, "back_to_back", g, d);
        checks++;
        if (g != 1) begin
            errors++;
            $display("FAIL back_to_back_grant: granted=%0d expected=1", g);
        end
    endtask

    task automatic test_timeout();
        int            g;
        logic [DW-1:0] d;
        run_txn(4, 0, 2, 1'b0, "timeout", g, d);
        run_txn(4, 5, 0, 1'b0, "after_timeout", g, d);
        run_txn(1, TIMEOUT, 0, 1'b0, "done_at_timeout", g, d);
        run_txn(2, TIMEOUT + 1, 0, 1'b0, "done_after_timeout", g, d);
    endtask

    task automatic test_reset_mid_busy();
        bit bad;
        do_reset();
        key_tb[0]  = {$urandom, $urandom, $urandom, $urandom};
        text_tb[0] = {$urandom, $urandom, $urandom, $urandom};
        req_valid  = 1;
        stub_lat   = 10;
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ptr = 0;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, core_ld, busy} !== '0 || rsp_data !== '0 ||
            core_key !== '0 || core_text !== '0) begin
            errors++;
            $display("FAIL reset_mid_busy: req_ready=%b rsp_valid=%b err=%b ld=%b busy=%b data=%h key=%h expected all 0",
                     req_ready, rsp_valid, rsp_err, core_ld, busy, rsp_data, core_key);
        end
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== '0 || core_ld !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL late_done: rsp_valid=%b ld=%b busy=%b expected quiet after reset", rsp_valid, core_ld, busy);
        end
    endtask

    task automatic test_random();
        int            g;
        logic [DW-1:0] d;
        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                key_tb[i]  = {$urandom, $urandom, $urandom, $urandom};
                text_tb[i] = {$urandom, $urandom, $urandom, $urandom};
            end
            run_txn(int'($urandom_range(1, (1 << NREQ) - 1)), int'($urandom_range(1, 12)),
                    int'($urandom_range(0, 3)), 1'($urandom), "random", g, d);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_timeout();
        test_reset_mid_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
